reg_native_apb_mst: RTL and testbench
=====================================

REG_NATIVE_APB_MST -- requirements
Module: reg_native_apb_mst

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, the address width on both sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width on both sides.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of ACCESS cycles; 0 disables the timeout.
REQ-004 SHALL have one clock and a synchronous, active-high reset (already decided), as the first two ports below.
REQ-005 clk  in  1  sole clock; every flop is clocked on its rising edge.
REQ-006 srst  in  1  synchronous active-high reset.
REQ-007 req_vld  in  1  native request strobe, one cycle.
REQ-008 wr_en  in  1  native write qualifier, sampled with req_vld.
REQ-009 rd_en  in  1  native read qualifier, sampled with req_vld.
REQ-010 addr  in  ADDR_WIDTH  native address.
REQ-011 wr_data  in  DATA_WIDTH  native write data.
REQ-012 ack_vld  out  1  native completion strobe, one cycle.
REQ-013 rd_data  out  DATA_WIDTH  read data, valid with ack_vld.
REQ-014 err  out  1  completion error flag, valid with ack_vld.
REQ-015 PSEL, PENABLE, PWRITE  out  1 each  APB initiator controls.
REQ-016 PADDR  out  ADDR_WIDTH  APB address.
REQ-017 PWDATA  out  DATA_WIDTH  APB write data.
REQ-018 PREADY, PSLVERR  in  1 each  APB completer response.
REQ-019 PRDATA  in  DATA_WIDTH  APB read data.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP and ACCESS, with every output registered.
REQ-021 IDLE, req_vld=1, exactly one of wr_en/rd_en set: SHALL latch addr, wr_data and direction, move to SETUP, and drive PSEL=1, PENABLE=0 on the next cycle.
REQ-022 PADDR and PWRITE SHALL hold the latched values from SETUP until the transfer ends.
REQ-023 PWDATA SHALL hold the latched wr_data for writes and SHALL be 0 for reads.
REQ-024 SETUP SHALL last exactly one cycle and then move to ACCESS with PENABLE=1.
REQ-025 ACCESS SHALL be held while PREADY=0; PADDR, PWRITE and PWDATA SHALL remain stable throughout.
REQ-026 ACCESS with PREADY=1: on the next cycle SHALL drive PSEL=0, PENABLE=0 and ack_vld=1, set err=PSLVERR, and return to IDLE.
REQ-027 On that completion, rd_data SHALL be PRDATA for reads and 0 for writes.
REQ-028 Minimum latency SHALL be 3 cycles: req_vld in cycle 0, PSEL in cycle 1, PENABLE in cycle 2, ack_vld in cycle 3 when PREADY is high in cycle 2.
REQ-029 A timeout counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0; its width SHALL be clog2(TIMEOUT+1).
REQ-030 When the counter equals TIMEOUT (TIMEOUT>0): on the next cycle SHALL drive PSEL=0, PENABLE=0, ack_vld=1, err=1, rd_data=0, and return to IDLE.
REQ-031 If PREADY=1 in the same cycle the timeout is reached, PREADY SHALL win and completion follows REQ-026/REQ-027.
REQ-032 req_vld with both or neither of wr_en/rd_en set in IDLE: no APB transfer; next cycle SHALL drive ack_vld=1, err=1, rd_data=0.
REQ-033 req_vld while not in IDLE SHALL be ignored; the upstream side guarantees at most one outstanding request.
REQ-034 req_vld in the same cycle as ack_vld=1 SHALL be accepted, since the FSM is already in IDLE.
REQ-035 ack_vld SHALL be high for exactly one cycle; rd_data and err SHALL hold their values until the next ack_vld.

Reset
REQ-036 srst=1 SHALL force IDLE and set to 0 on the next edge: PSEL, PENABLE, PWRITE, PADDR, PWDATA, ack_vld, rd_data, err and the timeout counter.
REQ-037 srst asserted mid-transfer SHALL abort the transfer with no ack_vld; any req_vld in a srst cycle SHALL be dropped.

Verification
REQ-038 Write addr=0x4, wr_data=0x1111_1111, PREADY=1 immediately -> PSEL in cycle 1, PENABLE in cycle 2, PWDATA=0x1111_1111, ack_vld in cycle 3 with err=0.
REQ-039 Read addr=0x0, PREADY delayed 5 cycles, PRDATA=0x2222_2222 -> PADDR stable throughout, ack_vld one cycle after PREADY, rd_data=0x2222_2222, err=0.
REQ-040 Write with PREADY=1 and PSLVERR=1 -> ack_vld with err=1; the next request completes with err=0.
REQ-041 TIMEOUT=4, PREADY held 0 -> 4 ACCESS cycles, then PSEL=0, ack_vld=1, err=1, rd_data=0; a second read completes normally.
REQ-042 req_vld with wr_en=rd_en=1 -> PSEL stays 0, ack_vld on the next cycle with err=1.
REQ-043 Back-to-back: second req_vld in the same cycle as the first ack_vld -> PSEL high again on the next cycle.
REQ-044 srst pulse during ACCESS -> all outputs 0 on the next edge, no ack_vld; a following read completes normally.

Source files
------------

// File: rtl/reg_native_apb_mst_if.sv
// Bundles the native request/completion handshake and the APB bus seen by
// the bridge. The master modport is the bridge's view; slave is the
// requester/completer environment around it.
interface reg_native_apb_mst_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  // native side
  logic                  req_vld;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ack_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  err;
  // APB side
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    input  req_vld, wr_en, rd_en, addr, wr_data,
    output ack_vld, rd_data, err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output req_vld, wr_en, rd_en, addr, wr_data,
    input  ack_vld, rd_data, err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/reg_native_apb_mst.sv
// Native single-request register port to APB initiator bridge.
// Every output is a flop; one transfer in flight at a time.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for req_vld; malformed requests are acked with err
//   SETUP  | APB setup phase, PSEL=1 PENABLE=0, always one cycle
//   ACCESS | APB access phase, PENABLE=1, wait for PREADY or timeout
module reg_native_apb_mst #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic                  clk,
  input logic                  srst,
  reg_native_apb_mst_if.master bus
);

  // Counter must reach TIMEOUT; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The cycle whose increment would land on TIMEOUT is the last ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                state_q,   state_d;
  logic                  psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q,  pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
  logic                  ack_vld_q, ack_vld_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  err_q,     err_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;

  logic                  req_ok;
  logic                  timeout_hit;

  assign req_ok      = bus.wr_en ^ bus.rd_en;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  // Next-state and next-output computation for the bridge FSM.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    ack_vld_d = 1'b0;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_vld) begin
          if (req_ok) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = bus.addr;
            pwrite_d  = bus.wr_en;
            pwdata_d  = bus.wr_en ? bus.wr_data : '0;
          end else begin
            // Malformed request: complete locally without touching APB.
            ack_vld_d = 1'b1;
            err_d     = 1'b1;
            rd_data_d = '0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        if (bus.PREADY) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_vld_d = 1'b1;
          err_d     = bus.PSLVERR;
          rd_data_d = pwrite_q ? '0 : bus.PRDATA;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_vld_d = 1'b1;
          err_d     = 1'b1;
          rd_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_vld_q <= 1'b0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ack_vld_q <= ack_vld_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.ack_vld = ack_vld_q;
  assign bus.rd_data = rd_data_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_reg_native_apb_mst.sv
// Bench for reg_native_apb_mst: two instances (default timeout and a short
// timeout of 4), a vector table of transfers, a completion scoreboard, and
// hand-written reset / back-to-back sequences.
module tb_reg_native_apb_mst;

  localparam int AW   = 64;
  localparam int DW   = 32;
  localparam int TO_B = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic          use_b;
  logic          req_vld, wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_native_apb_mst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  reg_native_apb_mst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  reg_native_apb_mst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_a (
    .clk (clk),
    .srst(srst),
    .bus (bus_a)
  );

  reg_native_apb_mst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO_B)) dut_b (
    .clk (clk),
    .srst(srst),
    .bus (bus_b)
  );

  assign bus_a.req_vld = req_vld & ~use_b;
  assign bus_b.req_vld = req_vld & use_b;
  assign bus_a.wr_en   = wr_en;
  assign bus_b.wr_en   = wr_en;
  assign bus_a.rd_en   = rd_en;
  assign bus_b.rd_en   = rd_en;
  assign bus_a.addr    = addr;
  assign bus_b.addr    = addr;
  assign bus_a.wr_data = wr_data;
  assign bus_b.wr_data = wr_data;
  assign bus_a.PREADY  = pready & ~use_b;
  assign bus_b.PREADY  = pready & use_b;
  assign bus_a.PSLVERR = pslverr;
  assign bus_b.PSLVERR = pslverr;
  assign bus_a.PRDATA  = prdata;
  assign bus_b.PRDATA  = prdata;

  logic          obs_psel, obs_penable, obs_pwrite, obs_ack, obs_err;
  logic [AW-1:0] obs_paddr;
  logic [DW-1:0] obs_pwdata, obs_rdata;

  assign obs_psel    = use_b ? bus_b.PSEL    : bus_a.PSEL;
  assign obs_penable = use_b ? bus_b.PENABLE : bus_a.PENABLE;
  assign obs_pwrite  = use_b ? bus_b.PWRITE  : bus_a.PWRITE;
  assign obs_paddr   = use_b ? bus_b.PADDR   : bus_a.PADDR;
  assign obs_pwdata  = use_b ? bus_b.PWDATA  : bus_a.PWDATA;
  assign obs_ack     = use_b ? bus_b.ack_vld : bus_a.ack_vld;
  assign obs_err     = use_b ? bus_b.err     : bus_a.err;
  assign obs_rdata   = use_b ? bus_b.rd_data : bus_a.rd_data;

  typedef struct {
    logic          use_b;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            dly;       // ACCESS cycles with PREADY low before PREADY
    logic          slverr;
    logic [DW-1:0] prdata;
    logic          exp_apb;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  vec_t vecs[12];
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every completion must match the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (obs_ack === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack_vld=1, expected no completion (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("ack_err", {63'd0, obs_err}, {63'd0, e.err});
          chk("ack_rdata", {32'd0, obs_rdata}, {32'd0, e.rdata});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drives one request and plays the APB completer. Returns in the cycle
  // where ack_vld is expected to be visible.
  task automatic do_txn(input vec_t v);
    int   n;
    bit   done;
    exp_t e;
    use_b   = v.use_b;
    req_vld = 1'b1;
    wr_en   = v.wr;
    rd_en   = v.rd;
    addr    = v.addr;
    wr_data = v.wdata;
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    tick();
    if (!v.exp_apb) begin
      req_vld = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      chk("bad_req_psel", {63'd0, obs_psel}, 64'd0);
      chk("bad_req_ack", {63'd0, obs_ack}, 64'd1);
      return;
    end
    // Busy-time requests and input garbage must be ignored.
    req_vld = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b0;
    addr    = {$urandom(), $urandom()};
    wr_data = $urandom();
    chk("setup_psel", {63'd0, obs_psel}, 64'd1);
    chk("setup_penable", {63'd0, obs_penable}, 64'd0);
    chk("setup_paddr", obs_paddr, v.addr);
    chk("setup_pwrite", {63'd0, obs_pwrite}, {63'd0, v.wr});
    chk("setup_pwdata", {32'd0, obs_pwdata}, {32'd0, (v.wr ? v.wdata : 32'd0)});
    tick();
    n    = 0;
    done = 1'b0;
    while (!done) begin
      chk("access_psel", {63'd0, obs_psel}, 64'd1);
      chk("access_penable", {63'd0, obs_penable}, 64'd1);
      chk("access_paddr", obs_paddr, v.addr);
      chk("access_pwrite", {63'd0, obs_pwrite}, {63'd0, v.wr});
      chk("access_pwdata", {32'd0, obs_pwdata}, {32'd0, (v.wr ? v.wdata : 32'd0)});
      chk("access_ack", {63'd0, obs_ack}, 64'd0);
      prdata = $urandom();
      if (n == v.dly) begin
        pready  = 1'b1;
        pslverr = v.slverr;
        prdata  = v.prdata;
        done    = 1'b1;
      end else if (v.use_b && n == TO_B - 1) begin
        done = 1'b1;
      end else if (n >= 300) begin
        n_vec++;
        n_bad++;
        $display("FAIL access_bound: got %0d ACCESS cycles, expected completion", n);
        done = 1'b1;
      end
      tick();
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom();
      n++;
    end
    req_vld = 1'b0;
    wr_en   = 1'b0;
    chk("done_psel", {63'd0, obs_psel}, 64'd0);
    chk("done_penable", {63'd0, obs_penable}, 64'd0);
    chk("done_ack", {63'd0, obs_ack}, 64'd1);
  endtask

  task automatic chk_all_zero(input string tag, input bit b);
    if (b) begin
      chk({tag, "_psel_b"}, {63'd0, bus_b.PSEL}, 64'd0);
      chk({tag, "_ack_b"}, {63'd0, bus_b.ack_vld}, 64'd0);
      chk({tag, "_paddr_b"}, bus_b.PADDR, 64'd0);
    end else begin
      chk({tag, "_psel"}, {63'd0, bus_a.PSEL}, 64'd0);
      chk({tag, "_penable"}, {63'd0, bus_a.PENABLE}, 64'd0);
      chk({tag, "_pwrite"}, {63'd0, bus_a.PWRITE}, 64'd0);
      chk({tag, "_paddr"}, bus_a.PADDR, 64'd0);
      chk({tag, "_pwdata"}, {32'd0, bus_a.PWDATA}, 64'd0);
      chk({tag, "_ack"}, {63'd0, bus_a.ack_vld}, 64'd0);
      chk({tag, "_rdata"}, {32'd0, bus_a.rd_data}, 64'd0);
      chk({tag, "_err"}, {63'd0, bus_a.err}, 64'd0);
    end
  endtask

  initial begin : main
    vec_t v;
    //          b  wr rd addr                    wdata          dly   serr prdata         apb err exp_rdata
    vecs[0]  = '{0, 1, 0, 64'h4,                 32'h1111_1111, 0,    0,   32'hCAFE_0001, 1,  0,  32'h0};
    vecs[1]  = '{0, 0, 1, 64'h0,                 32'h9999_9999, 5,    0,   32'h2222_2222, 1,  0,  32'h2222_2222};
    vecs[2]  = '{0, 1, 0, 64'h10,                32'h0BAD_0BAD, 0,    1,   32'h1234_5678, 1,  1,  32'h0};
    vecs[3]  = '{0, 0, 1, 64'h8,                 32'h0,         0,    0,   32'h0000_3333, 1,  0,  32'h0000_3333};
    vecs[4]  = '{0, 1, 1, 64'h40,                32'h7,         0,    0,   32'h0,         0,  1,  32'h0};
    vecs[5]  = '{0, 0, 0, 64'h44,                32'h7,         0,    0,   32'h0,         0,  1,  32'h0};
    vecs[6]  = '{0, 0, 1, 64'hC,                 32'h0,         2,    1,   32'hDEAD_BEEF, 1,  1,  32'hDEAD_BEEF};
    vecs[7]  = '{0, 1, 0, 64'hFFFF_0000_1234_5678, 32'hA5A5_5A5A, 1,  0,   32'h5555_5555, 1,  0,  32'h0};
    vecs[8]  = '{1, 0, 1, 64'h100,               32'h0,         1000, 0,   32'hFFFF_FFFF, 1,  1,  32'h0};
    vecs[9]  = '{1, 0, 1, 64'h104,               32'h0,         0,    0,   32'h0000_5555, 1,  0,  32'h0000_5555};
    vecs[10] = '{1, 0, 1, 64'h108,               32'h0,         3,    0,   32'h0000_6666, 1,  0,  32'h0000_6666};
    vecs[11] = '{1, 1, 0, 64'h10C,               32'h7777_7777, 2,    0,   32'h8888_8888, 1,  0,  32'h0};

    use_b   = 1'b0;
    srst    = 1'b1;
    req_vld = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = '0;
    wr_data = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;

    // Reset, with a request presented during reset that must be dropped.
    tick();
    req_vld = 1'b1;
    wr_en   = 1'b1;
    addr    = 64'h4;
    wr_data = 32'h1;
    tick();
    chk_all_zero("reset", 1'b0);
    chk_all_zero("reset", 1'b1);
    srst    = 1'b0;
    req_vld = 1'b0;
    wr_en   = 1'b0;
    tick();
    chk("rst_drop_psel", {63'd0, bus_a.PSEL}, 64'd0);
    chk("rst_drop_ack", {63'd0, bus_a.ack_vld}, 64'd0);

    // Table of single transfers, each followed by an idle hold check.
    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i]);
      tick();
      chk("ack_pulse", {63'd0, obs_ack}, 64'd0);
      chk("err_hold", {63'd0, obs_err}, {63'd0, vecs[i].exp_err});
      chk("rdata_hold", {32'd0, obs_rdata}, {32'd0, vecs[i].exp_rdata});
    end

    // Back-to-back: second request issued in the first ack cycle.
    v = '{0, 0, 1, 64'h200, 32'h0, 0, 0, 32'hA5A5_0001, 1, 0, 32'hA5A5_0001};
    do_txn(v);
    v = '{0, 0, 1, 64'h204, 32'h0, 1, 1, 32'h5A5A_0002, 1, 1, 32'h5A5A_0002};
    do_txn(v);
    tick();
    chk("b2b_ack_pulse", {63'd0, obs_ack}, 64'd0);

    // Reset pulse during ACCESS aborts the write with no completion.
    use_b   = 1'b0;
    req_vld = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b0;
    addr    = 64'h20;
    wr_data = 32'h0000_0077;
    tick();
    req_vld = 1'b0;
    wr_en   = 1'b0;
    chk("abort_setup_psel", {63'd0, obs_psel}, 64'd1);
    tick();
    chk("abort_access_penable", {63'd0, obs_penable}, 64'd1);
    chk("abort_access_pwdata", {32'd0, obs_pwdata}, 64'h77);
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk_all_zero("abort", 1'b0);
    tick();
    chk("abort_idle_psel", {63'd0, obs_psel}, 64'd0);
    chk("abort_idle_ack", {63'd0, obs_ack}, 64'd0);

    v = '{0, 0, 1, 64'h24, 32'h0, 1, 0, 32'h0F0F_0F0F, 1, 0, 32'h0F0F_0F0F};
    do_txn(v);
    tick();
    tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
